btb_update_ctrl: RTL and testbench

Write-side controller for the branch target buffer. Accepts resolved control-flow outcomes from EX, buffers them in a small in-order FIFO, and serialises them onto the BTB's single write port, which the BTB can stall. It owns the BTB's invalidation sequencing: a full-table sweep after reset and on an explicit `inv_all` request, so the BTB needs no reset loop of its own.

---
 rtl/btb_update_ctrl.sv | 134 +++++++++++++
 tb/tb_btb_update_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: buffers resolved EX outcomes in an in-order FIFO
// and serialises them onto the stallable BTB write port; owns table-wide invalidation sweeps.
module btb_update_ctrl #(
  parameter int ENTRY_BIT  = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int TAG_BIT   = 32 - ENTRY_BIT - 2,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_is_branch,
  input  logic                 upd_taken,
  output logic                 upd_ready,
  input  logic                 inv_all,
  input  logic                 wr_stall,
  output logic                 wr_en,
  output logic [ENTRY_BIT-1:0] wr_idx,
  output logic                 wr_val,
  output logic [TAG_BIT-1:0]   wr_tag,
  output logic [31:0]          wr_target,
  output logic                 wr_is_branch,
  output logic                 wr_taken,
  output logic                 busy,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_INV} state_t;

  state_t               state, state_next;
  logic [ENTRY_BIT-1:0] sweep_idx;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push, pop, flush;

  // Entries keep pc[31:2]; the byte-offset bits never reach the BTB.
  logic [29:0] mem_pc     [FIFO_DEPTH];
  logic [31:0] mem_target [FIFO_DEPTH];
  logic        mem_is_br  [FIFO_DEPTH];
  logic        mem_taken  [FIFO_DEPTH];

  logic unused_pc_bits;
  assign unused_pc_bits = ^upd_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Outputs are gated by reset so the port is quiet even before state is known.
  always_comb begin
    state_next   = state;
    wr_en        = 1'b0;
    wr_idx       = '0;
    wr_val       = 1'b0;
    wr_tag       = '0;
    wr_target    = '0;
    wr_is_branch = 1'b0;
    wr_taken     = 1'b0;
    upd_ready    = 1'b0;
    busy         = 1'b1;
    flush        = 1'b0;
    pop          = 1'b0;
    if (!reset) begin
      case (state)
        S_INIT, S_INV: begin
          wr_en  = 1'b1;
          wr_idx = sweep_idx;
          if (!wr_stall && sweep_idx == '1) state_next = S_RUN;
        end
        S_RUN: begin
          busy         = 1'b0;
          wr_idx       = mem_pc[rd_ptr][ENTRY_BIT-1:0];
          wr_tag       = mem_pc[rd_ptr][29:ENTRY_BIT];
          wr_val       = 1'b1;
          wr_target    = mem_target[rd_ptr];
          wr_is_branch = mem_is_br[rd_ptr];
          wr_taken     = mem_taken[rd_ptr];
          if (inv_all) begin
            state_next = S_INV;
            flush      = 1'b1;
          end else begin
            wr_en     = (count != '0);
            pop       = wr_en && !wr_stall;
            upd_ready = (count < CNT_W'(FIFO_DEPTH));
          end
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  assign push       = upd_valid && upd_ready;
  assign fifo_count = reset ? '0 : count;

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_idx <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      // Index wraps back to 0 on the final sweep write.
      if (state != S_RUN && !wr_stall) sweep_idx <= sweep_idx + 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]     <= upd_pc[31:2];
      mem_target[wr_ptr] <= upd_target;
      mem_is_br[wr_ptr]  <= upd_is_branch;
      mem_taken[wr_ptr]  <= upd_taken && upd_is_branch;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: scoreboard of expected BTB writes checked
// by a negedge monitor, plus handshake/occupancy checks in one stimulus sequence.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        reset, upd_valid, upd_is_branch, upd_taken, inv_all, wr_stall;
  logic [31:0] upd_pc, upd_target;
  logic        upd_ready, wr_en, wr_val, wr_is_branch, wr_taken, busy;
  logic [4:0]  wr_idx;
  logic [24:0] wr_tag;
  logic [31:0] wr_target;
  logic [2:0]  fifo_count;

  typedef struct packed {
    logic [4:0]  idx;
    logic        val;
    logic [24:0] tag;
    logic [31:0] target;
    logic        is_br;
    logic        taken;
  } wr_rec_t;

  wr_rec_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  btb_update_ctrl #(.ENTRY_BIT(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .inv_all(inv_all), .wr_stall(wr_stall), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_val(wr_val), .wr_tag(wr_tag), .wr_target(wr_target),
    .wr_is_branch(wr_is_branch), .wr_taken(wr_taken), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completed writes are compared in order against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en === 1'b1 && wr_stall === 1'b0) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed idx %0h val %0b expected no write", wr_idx, wr_val);
      end
      if (sb.size() != 0)
        chk("write_rec", 96'({wr_idx, wr_val, wr_tag, wr_target, wr_is_branch, wr_taken}),
            96'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    wr_rec_t r;
    for (int unsigned i = 0; i < 32; i++) begin
      r = '0;
      r.idx = 5'(i);
      sb.push_back(r);
    end
  endtask

  task automatic run_sweep(input string tag);
    for (int unsigned i = 0; i < 32; i++) begin
      #1;
      chk({tag, "_busy"}, 96'(busy), 96'(1));
      chk({tag, "_ready"}, 96'(upd_ready), 96'(0));
      chk({tag, "_idx"}, 96'(wr_idx), 96'(i));
      tick();
    end
    #1;
    chk({tag, "_done_busy"}, 96'(busy), 96'(0));
    chk({tag, "_done_ready"}, 96'(upd_ready), 96'(1));
    chk({tag, "_done_wr_en"}, 96'(wr_en), 96'(0));
    chk({tag, "_sb_empty"}, 96'(sb.size()), 96'(0));
  endtask

  // Drives one offer; caller advances the clock.
  task automatic offer(input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                       input logic tk, input logic exp_ready);
    wr_rec_t r;
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_is_branch = br; upd_taken = tk;
    #1;
    chk("upd_ready", 96'(upd_ready), 96'(exp_ready));
    if (exp_ready) begin
      r.idx = pc[6:2]; r.val = 1'b1; r.tag = pc[31:7];
      r.target = tgt; r.is_br = br; r.taken = br & tk;
      sb.push_back(r);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_is_branch = 1'b0; upd_taken = 1'b0; inv_all = 1'b0; wr_stall = 1'b0;

    // 1: reset and initial sweep
    tick();
    #1;
    chk("rst_wr_en", 96'(wr_en), 96'(0));
    chk("rst_ready", 96'(upd_ready), 96'(0));
    chk("rst_busy", 96'(busy), 96'(1));
    chk("rst_count", 96'(fifo_count), 96'(0));
    chk("rst_wr_bus", 96'({wr_idx, wr_val, wr_tag, wr_target, wr_is_branch, wr_taken}), 96'(0));
    tick();
    reset = 1'b0;
    push_sweep();
    run_sweep("init");

    // 2: single update
    offer(32'h104, 32'h200, 1'b1, 1'b1, 1'b1);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("single_wr_en", 96'(wr_en), 96'(1));
    chk("single_count", 96'(fifo_count), 96'(1));
    tick();
    chk("single_after_wr_en", 96'(wr_en), 96'(0));
    chk("single_after_count", 96'(fifo_count), 96'(0));

    // 3: fill under stall, no push-through when full
    wr_stall = 1'b1;
    offer(32'h10, 32'h1000, 1'b1, 1'b0, 1'b1); tick();
    offer(32'h14, 32'h2004, 1'b0, 1'b0, 1'b1); tick();
    offer(32'h18, 32'h3008, 1'b1, 1'b1, 1'b1); tick();
    offer(32'h1C, 32'h400C, 1'b0, 1'b0, 1'b1); tick();
    offer(32'h20, 32'h5010, 1'b1, 1'b1, 1'b0); tick();
    upd_valid = 1'b0;
    #1;
    chk("full_count", 96'(fifo_count), 96'(4));
    chk("full_ready", 96'(upd_ready), 96'(0));
    chk("full_stalled_idx", 96'(wr_idx), 96'(4));
    wr_stall = 1'b0;
    #1;
    chk("full_pop_ready", 96'(upd_ready), 96'(0));
    tick();
    chk("after_pop_ready", 96'(upd_ready), 96'(1));
    chk("after_pop_count", 96'(fifo_count), 96'(3));
    tick(); tick(); tick();
    chk("drain_count", 96'(fifo_count), 96'(0));
    chk("drain_sb", 96'(sb.size()), 96'(0));

    // Simultaneous push and pop keeps occupancy
    offer(32'h80, 32'h6000, 1'b0, 1'b0, 1'b1); tick();
    offer(32'h84, 32'h7000, 1'b1, 1'b1, 1'b1);
    chk("pushpop_wr_en", 96'(wr_en), 96'(1));
    tick();
    upd_valid = 1'b0;
    chk("pushpop_count", 96'(fifo_count), 96'(1));
    tick();
    chk("pushpop_drained", 96'(fifo_count), 96'(0));

    // 4: inv_all drops pending updates
    wr_stall = 1'b1;
    offer(32'h40, 32'h8000, 1'b1, 1'b1, 1'b1); tick();
    offer(32'h44, 32'h9000, 1'b0, 1'b0, 1'b1); tick();
    upd_valid = 1'b0;
    chk("inv_pre_count", 96'(fifo_count), 96'(2));
    inv_all = 1'b1;
    offer(32'h48, 32'hA000, 1'b1, 1'b1, 1'b0);
    chk("inv_cycle_wr_en", 96'(wr_en), 96'(0));
    tick();
    inv_all = 1'b0; upd_valid = 1'b0; wr_stall = 1'b0;
    sb.delete();
    push_sweep();
    #1;
    chk("inv_count", 96'(fifo_count), 96'(0));
    chk("inv_busy", 96'(busy), 96'(1));
    run_sweep("inv");

    // 5: reset mid-sweep
    reset = 1'b1; tick(); reset = 1'b0;
    push_sweep();
    for (int unsigned i = 0; i < 10; i++) tick();
    chk("mid_idx", 96'(wr_idx), 96'(10));
    chk("mid_sb_left", 96'(sb.size()), 96'(22));
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_wr_en", 96'(wr_en), 96'(0));
    chk("mid_rst_busy", 96'(busy), 96'(1));
    tick();
    reset = 1'b0;
    push_sweep();
    run_sweep("restart");

    // 6: stall during sweep
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    push_sweep();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      wr_stall = (n >= 7 && n <= 9);
      #1;
      if (n >= 7 && n <= 10) chk("stall_idx_hold", 96'(wr_idx), 96'(7));
      n++;
      tick();
    end
    wr_stall = 1'b0;
    chk("stall_sweep_len", 96'(n), 96'(35));
    chk("stall_sb_empty", 96'(sb.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
